stream_mux_rr: RTL

Parametrised N-channel, W-bit stream multiplexer with a registered output stage and valid/ready handshaking on every channel. It extends the combinational 2:1 select into a sequential block. Input channels are chosen either by an external select (fixed mode) or by a fair round-robin arbiter (RR mode). It sits between multiple producer streams and a single consumer, and also counts completed output transfers.

---
 rtl/stream_mux_rr.sv | 90 +++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single-entry registered output,
// fixed-select or round-robin arbitration, and a wrapping transfer counter.
module stream_mux_rr #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = $clog2(NCH),
  parameter int unsigned CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  output logic [NCH-1:0]         in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SELW-1:0]        out_ch,
  output logic [CNTW-1:0]        xfer_cnt
);

  logic [SELW-1:0]        ptr;
  logic [SELW-1:0]        rr_ch;
  logic                   rr_ok;
  logic                   fx_ok;
  logic [SELW-1:0]        cand;
  logic                   cand_ok;
  logic                   load_en;
  logic                   grant;
  logic [WIDTH-1:0]       cand_data;
  logic [(1<<SELW)-1:0]   valid_pad;

  // Zero-extended valid vector so out-of-range sel values read as not valid.
  always_comb begin
    valid_pad            = '0;
    valid_pad[NCH-1:0]   = in_valid;
    fx_ok                = (32'(sel) < NCH) && valid_pad[sel];
  end

  // Scan ptr+1, ptr+2, ... modulo NCH; the first valid channel wins.
  always_comb begin
    rr_ch = ptr;
    rr_ok = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      if (!rr_ok && in_valid[(32'(ptr) + k) % NCH]) begin
        rr_ok = 1'b1;
        rr_ch = SELW'((32'(ptr) + k) % NCH);
      end
    end
  end

  always_comb begin
    cand      = mode ? rr_ch : sel;
    cand_ok   = mode ? rr_ok : fx_ok;
    load_en   = !out_valid || out_ready;
    grant     = rst_n && load_en && cand_ok;
    cand_data = in_data[32'(cand)*WIDTH +: WIDTH];
    in_ready  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      in_ready[i] = grant && (32'(cand) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      xfer_cnt  <= '0;
      ptr       <= SELW'(NCH - 1);
    end else begin
      // A grant only happens when the register is empty or draining this cycle.
      if (grant) begin
        out_data  <= cand_data;
        out_ch    <= cand;
        out_valid <= 1'b1;
        if (mode) begin
          ptr <= cand;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) begin
        xfer_cnt <= xfer_cnt + CNTW'(1);
      end
    end
  end

endmodule
